// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Deframes 11-bit PS/2 frames from the debounced keyboard lines and folds
// E0 (extended) and F0 (break) prefix bytes into single key events. Events
// sit in a small FIFO and are handed to the game input logic over a
// valid/ready handshake. Framing faults and timeouts raise a one-cycle
// frame_err pulse. A push into a full FIFO with no pop in the same cycle
// raises a one-cycle overflow pulse.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int TIMEOUT_WIDTH  = 15,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_AW        = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_db,
  input  logic       ps2_data_db,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       frame_err,
  output logic       overflow
);

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST   = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_AW:0]         FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]               PREFIX_EXT = 8'hE0;
  localparam logic [7:0]               PREFIX_BRK = 8'hF0;

  // ---------------------------------------------------------------------------
  // PS/2 clock falling-edge detection
  // ---------------------------------------------------------------------------
  logic prev_clk_reg;
  logic fall;

  // Remember last PS/2 clock level; idles high so reset never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_clk_reg <= 1'b1;
    end else begin
      prev_clk_reg <= ps2_clk_db;
    end
  end

  assign fall = prev_clk_reg & ~ps2_clk_db;

  // ---------------------------------------------------------------------------
  // Frame FSM: start, 8 data bits LSB first, odd parity, stop
  // ---------------------------------------------------------------------------
  state_t                   state_reg,     state_next;
  logic [2:0]               bit_idx_reg,   bit_idx_next;
  logic [7:0]               shift_reg,     shift_next;
  logic                     parity_ok_reg, parity_ok_next;
  logic [TIMEOUT_WIDTH-1:0] tmo_reg,       tmo_next;
  logic                     byte_done_reg, byte_done_next;
  logic [7:0]               byte_reg,      byte_next;
  logic                     frame_err_reg, frame_err_next;

  // Frame FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_idx_reg   <= 3'd0;
      shift_reg     <= 8'd0;
      parity_ok_reg <= 1'b0;
      tmo_reg       <= '0;
      byte_done_reg <= 1'b0;
      byte_reg      <= 8'd0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      parity_ok_reg <= parity_ok_next;
      tmo_reg       <= tmo_next;
      byte_done_reg <= byte_done_next;
      byte_reg      <= byte_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Next-state, bit sampling on PS/2 falling edges, and the inactivity timeout
  always_comb begin
    state_next     = state_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    parity_ok_next = parity_ok_reg;
    tmo_next       = tmo_reg;
    byte_done_next = 1'b0;
    byte_next      = byte_reg;
    frame_err_next = 1'b0;

    // The timeout only guards a partially received frame; any edge restarts it.
    if (state_reg == IDLE) begin
      tmo_next = '0;
    end else if (fall) begin
      tmo_next = '0;
    end else if (tmo_reg == TMO_LAST) begin
      tmo_next       = '0;
      state_next     = IDLE;
      frame_err_next = 1'b1;
    end else begin
      tmo_next = tmo_reg + 1'b1;
    end

    if (fall) begin
      case (state_reg)
        IDLE: begin
          if (!ps2_data_db) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
          end else begin
            // A high start bit means we are out of step with the keyboard.
            frame_err_next = 1'b1;
          end
        end
        DATA: begin
          shift_next = {ps2_data_db, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = PARITY;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
        PARITY: begin
          // Odd parity: data plus parity bit must have an odd number of ones.
          parity_ok_next = ^{ps2_data_db, shift_reg};
          state_next     = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (ps2_data_db && parity_ok_reg) begin
            byte_done_next = 1'b1;
            byte_next      = shift_reg;
          end else begin
            frame_err_next = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte layer: fold E0/F0 prefixes into the next key byte
  // ---------------------------------------------------------------------------
  logic       ext_reg;
  logic       brk_reg;
  logic       push;
  logic [9:0] push_entry;

  assign push       = byte_done_reg && (byte_reg != PREFIX_EXT) && (byte_reg != PREFIX_BRK);
  assign push_entry = {ext_reg, brk_reg, byte_reg};

  // Prefix flags: set by E0/F0, consumed by the key byte, dropped on any error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_reg <= 1'b0;
      brk_reg <= 1'b0;
    end else if (frame_err_reg) begin
      ext_reg <= 1'b0;
      brk_reg <= 1'b0;
    end else if (byte_done_reg) begin
      if (byte_reg == PREFIX_EXT) begin
        ext_reg <= 1'b1;
      end else if (byte_reg == PREFIX_BRK) begin
        brk_reg <= 1'b1;
      end else begin
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO: entry = {extended, release, code}
  // ---------------------------------------------------------------------------
  logic [9:0]         mem_reg [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg;
  logic               overflow_reg;
  logic               empty;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic [9:0]         head;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);
  assign pop   = !empty && key_ready;
  // When full, a push can still land if the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  // Storage array; contents are only visible through key_valid gating
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  // Pointers, occupancy and the overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= push && full && !pop;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head entry is read combinationally so a pop shows the next entry at once
  assign head = mem_reg[rd_ptr_reg];

  assign key_valid    = !empty;
  assign key_code     = key_valid ? head[7:0] : 8'd0;
  assign key_release  = key_valid ? head[8]   : 1'b0;
  assign key_extended = key_valid ? head[9]   : 1'b0;
  assign frame_err    = frame_err_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: a table of frames with expected events and
// errors, plus hand-written sequences for latency, start-bit error, timeout,
// overflow/drain and asynchronous reset.
module tb_ps2_key_decoder;

  localparam int TMO  = 200;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk_db = 1'b1;
  logic       ps2_data_db = 1'b1;
  logic       key_ready = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_release;
  logic       key_extended;
  logic       frame_err;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_WIDTH (15),
    .FIFO_DEPTH    (4),
    .FIFO_AW       (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk_db  (ps2_clk_db),
    .ps2_data_db (ps2_data_db),
    .key_ready   (key_ready),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_release (key_release),
    .key_extended(key_extended),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  int tests = 0;
  int fails = 0;

  // Monitor: accepted events and pulse cycles, sampled on the falling clk edge
  int         err_cnt = 0;
  int         ovf_cnt = 0;
  logic [9:0] ev_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid && key_ready) ev_q.push_back({key_extended, key_release, key_code});
      if (frame_err) err_cnt++;
      if (overflow) ovf_cnt++;
    end
  end

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    int         exp_ev;
    logic [9:0] exp_entry;   // {extended, release, code}
    int         exp_err;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One PS/2 bit: data set up while clock high, then a low half-period
  task automatic ps2_bit(input logic b);
    @(posedge clk); #1 ps2_data_db = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk_db = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk_db = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^d) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(!bad_stop);
    @(posedge clk); #1 ps2_data_db = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  function automatic vec_t mk(input logic [7:0] d, input bit bp, input bit bs,
                              input int ev, input logic [9:0] ent, input int er);
    vec_t v;
    v.data = d; v.bad_par = bp; v.bad_stop = bs;
    v.exp_ev = ev; v.exp_entry = ent; v.exp_err = er;
    return v;
  endfunction

  initial begin
    int         ev_rd;
    int         err_base;
    int         ovf_base;
    int         got;
    logic [7:0] drain_exp[4];
    logic [7:0] byte_1c;

    vecs[0]  = mk(8'h1C, 0, 0, 1, {1'b0, 1'b0, 8'h1C}, 0);
    vecs[1]  = mk(8'hF0, 0, 0, 0, 10'h000,             0);
    vecs[2]  = mk(8'h1C, 0, 0, 1, {1'b0, 1'b1, 8'h1C}, 0);
    vecs[3]  = mk(8'hE0, 0, 0, 0, 10'h000,             0);
    vecs[4]  = mk(8'hF0, 0, 0, 0, 10'h000,             0);
    vecs[5]  = mk(8'h75, 0, 0, 1, {1'b1, 1'b1, 8'h75}, 0);
    vecs[6]  = mk(8'h75, 0, 0, 1, {1'b0, 1'b0, 8'h75}, 0);
    vecs[7]  = mk(8'h1C, 1, 0, 0, 10'h000,             1);
    vecs[8]  = mk(8'h1B, 0, 0, 1, {1'b0, 1'b0, 8'h1B}, 0);
    vecs[9]  = mk(8'hE0, 0, 0, 0, 10'h000,             0);
    vecs[10] = mk(8'h1C, 1, 0, 0, 10'h000,             1);
    vecs[11] = mk(8'h2B, 0, 0, 1, {1'b0, 1'b0, 8'h2B}, 0);
    vecs[12] = mk(8'hF0, 0, 0, 0, 10'h000,             0);
    vecs[13] = mk(8'h34, 0, 1, 0, 10'h000,             1);
    vecs[14] = mk(8'h34, 0, 0, 1, {1'b0, 1'b0, 8'h34}, 0);
    vecs[15] = mk(8'hE0, 0, 0, 0, 10'h000,             0);
    vecs[16] = mk(8'h6B, 0, 0, 1, {1'b1, 1'b0, 8'h6B}, 0);
    drain_exp[0] = 8'h1C; drain_exp[1] = 8'h1B; drain_exp[2] = 8'h23; drain_exp[3] = 8'h2B;
    byte_1c = 8'h1C;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {key_valid, key_code, key_release, key_extended, frame_err, overflow}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    $display("[TB] reset released");

    // Latency: valid rises two clk edges after the stop-bit fall
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(byte_1c[i]);
    ps2_bit(1'b0);
    @(posedge clk); #1 ps2_data_db = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk_db = 1'b0;
    @(negedge clk); check("lat_before_E", key_valid, 0);
    @(negedge clk); check("lat_after_E", key_valid, 0);
    @(negedge clk); check("lat_after_E1", {key_valid, key_extended, key_release, key_code}, {1'b1, 1'b0, 1'b0, 8'h1C});
    repeat (HALF) @(posedge clk);
    #1 ps2_clk_db = 1'b1; key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("lat_drained", key_valid, 0);
    $display("[TB] latency make 1C done");
    ev_rd = ev_q.size();

    // Table-driven frames
    for (int i = 0; i < 17; i++) begin
      err_base = err_cnt;
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
      got = ev_q.size() - ev_rd;
      check($sformatf("vec%0d_events", i), got, vecs[i].exp_ev);
      if (vecs[i].exp_ev == 1 && got >= 1)
        check($sformatf("vec%0d_entry", i), ev_q[ev_rd], vecs[i].exp_entry);
      check($sformatf("vec%0d_err", i), err_cnt - err_base, vecs[i].exp_err);
      $display("[TB] vec%0d byte %02h events %0d errs %0d", i, vecs[i].data, got, err_cnt - err_base);
      ev_rd = ev_q.size();
    end

    // High start bit in IDLE
    err_base = err_cnt;
    ps2_bit(1'b1);
    repeat (4) @(posedge clk);
    #1 check("start_bit_err", err_cnt - err_base, 1);
    check("start_bit_no_event", ev_q.size() - ev_rd, 0);
    $display("[TB] start-bit error errs %0d", err_cnt - err_base);

    // Timeout after start + 4 data bits
    err_base = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    @(posedge clk); #1 ps2_data_db = 1'b1;
    for (int c = 0; c < TMO + 50 && err_cnt == err_base; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("timeout_err_one_cycle", err_cnt - err_base, 1);
    check("timeout_no_event", ev_q.size() - ev_rd, 0);
    send_frame(8'h1C, 0, 0);
    check("post_timeout_events", ev_q.size() - ev_rd, 1);
    if (ev_q.size() > ev_rd) check("post_timeout_entry", ev_q[ev_rd], {2'b00, 8'h1C});
    $display("[TB] timeout errs %0d then events %0d", err_cnt - err_base, ev_q.size() - ev_rd);
    ev_rd = ev_q.size();

    // Overflow with consumer stalled, then back-to-back drain
    @(posedge clk); #1 key_ready = 1'b0;
    ovf_base = ovf_cnt;
    send_frame(8'h1C, 0, 0);
    send_frame(8'h1B, 0, 0);
    send_frame(8'h23, 0, 0);
    send_frame(8'h2B, 0, 0);
    check("ovf_before_5th", ovf_cnt - ovf_base, 0);
    send_frame(8'h34, 0, 0);
    check("ovf_on_5th", ovf_cnt - ovf_base, 1);
    check("ovf_head_stable", {key_valid, key_code}, {1'b1, 8'h1C});
    $display("[TB] overflow pulses %0d", ovf_cnt - ovf_base);
    @(posedge clk); #1 key_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("drain%0d", k), {key_valid, key_code}, {1'b1, drain_exp[k]});
      $display("[TB] drain%0d code %02h", k, key_code);
    end
    @(negedge clk); check("drain_empty", key_valid, 0);
    ev_rd = ev_q.size();

    // Asynchronous reset mid-prefix and mid-frame with an event queued
    @(posedge clk); #1 key_ready = 1'b0;
    send_frame(8'hE0, 0, 0);
    send_frame(8'h1C, 0, 0);
    check("pre_reset_queued", {key_valid, key_extended, key_code}, {1'b1, 1'b1, 8'h1C});
    send_frame(8'hE0, 0, 0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {key_valid, key_code, key_release, key_extended, frame_err, overflow}, 0);
    @(negedge clk); check("reset_held_outputs", {key_valid, frame_err, overflow}, 0);
    @(posedge clk); #1 rst_n = 1'b1; ps2_data_db = 1'b1; key_ready = 1'b1;
    ev_rd = ev_q.size();
    err_base = err_cnt;
    send_frame(8'h2B, 0, 0);
    check("post_reset_events", ev_q.size() - ev_rd, 1);
    if (ev_q.size() > ev_rd) check("post_reset_entry", ev_q[ev_rd], {2'b00, 8'h2B});
    check("post_reset_err", err_cnt - err_base, 0);
    $display("[TB] post-reset 2B events %0d", ev_q.size() - ev_rd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
